// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one downstream SRAM-style port between the CPU instruction fetch
//   and the CPU load/store port. Only one downstream transaction is in flight
//   at a time. When both sides are waiting in IDLE, the data side goes first.
//   A transaction that has started always runs to completion.
//
//   Per-owner done flags keep the stall low once the result is back. A flag
//   stays set while the pipeline is frozen and clears on the first clock edge
//   where the pipeline advances.
//
// State table
//   state | meaning
//   IDLE  | no transaction outstanding; pick data, then inst
//   ADDR  | mem_req asserted, waiting for mem_addr_ok
//   DATA  | address accepted, waiting for mem_data_ok
//
// Ports
//   clk, rst                 clock, async active-high reset
//   inst_req/inst_addr       fetch request (held while stalled)
//   inst_rdata/i_stall       fetched word, fetch not yet complete
//   data_req/data_wen/       load/store request; data_wen != 0 is a store
//   data_addr/data_wdata
//   data_rdata/d_stall       loaded word, access not yet complete
//   longest_stall            pipeline frozen this cycle
//   mem_req/mem_wr/mem_wen/  downstream request, held from ADDR entry
//   mem_addr/mem_wdata       until the return to IDLE
//   mem_addr_ok/mem_data_ok  downstream address accept / completion
//   mem_rdata                downstream read data
module sram_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        i_stall,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        d_stall,
    input  logic        longest_stall,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arbStateT;

    arbStateT curState;
    arbStateT nextState;

    logic instDone;
    logic dataDone;
    logic ownerData;
    logic startData;
    logic startInst;
    logic finish;

    assign i_stall = inst_req & ~instDone;
    assign d_stall = data_req & ~dataDone;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            curState <= IDLE;
        end else begin
            curState <= nextState;
        end
    end

    always_comb begin
        nextState = curState;
        startData = 1'b0;
        startInst = 1'b0;
        finish    = 1'b0;
        mem_req   = 1'b0;
        case (curState)
            IDLE: begin
                if (d_stall) begin
                    startData = 1'b1;
                    nextState = ADDR;
                end else if (i_stall) begin
                    startInst = 1'b1;
                    nextState = ADDR;
                end
            end
            ADDR: begin
                mem_req = 1'b1;
                if (mem_addr_ok) begin
                    nextState = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    finish    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr     <= 1'b0;
            mem_wen    <= 4'h0;
            mem_addr   <= 32'h0;
            mem_wdata  <= 32'h0;
            ownerData  <= 1'b0;
            inst_rdata <= 32'h0;
            data_rdata <= 32'h0;
            instDone   <= 1'b0;
            dataDone   <= 1'b0;
        end else begin
            if (startData) begin
                mem_wr    <= |data_wen;
                mem_wen   <= data_wen;
                mem_addr  <= data_addr;
                mem_wdata <= data_wdata;
                ownerData <= 1'b1;
            end else if (startInst) begin
                mem_wr    <= 1'b0;
                mem_wen   <= 4'h0;
                mem_addr  <= inst_addr;
                ownerData <= 1'b0;
            end

            if (finish && !ownerData) begin
                inst_rdata <= mem_rdata;
            end
            if (finish && ownerData && !mem_wr) begin
                data_rdata <= mem_rdata;
            end

            // A completing transaction wins over the advance-clear.
            if (finish && !ownerData) begin
                instDone <= 1'b1;
            end else if (!longest_stall) begin
                instDone <= 1'b0;
            end
            if (finish && ownerData) begin
                dataDone <= 1'b1;
            end else if (!longest_stall) begin
                dataDone <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        longest_stall;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    int vecCount = 0;
    int errCount = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .i_stall(i_stall),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .d_stall(d_stall), .longest_stall(longest_stall),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        isData;
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          aDly;
        int          dDly;
        logic        expWr;
        logic [3:0]  expWen;
        logic [31:0] expIRdata;
        logic [31:0] expDRdata;
    } vecT;

    vecT vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expV);
        vecCount++;
        if (act !== expV) begin
            errCount++;
            $display("FAIL %s: got %h expected %h", name, act, expV);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        inst_req = 0; inst_addr = 0; data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        longest_stall = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    // Single isolated transaction with a scripted slave; expected timeline
    // comes from the table's delays: mem_req during cycles 1..1+aDly,
    // stall low at cycle 3+aDly+dDly.
    task automatic runVec(input vecT v, input int idx);
        int lat;
        lat = 3 + v.aDly + v.dDly;
        for (int k = 0; k <= lat; k++) begin
            if (v.isData) begin
                data_req = 1; data_wen = v.wen; data_addr = v.addr; data_wdata = v.wdata;
            end else begin
                inst_req = 1; inst_addr = v.addr;
            end
            mem_addr_ok   = (k == 1 + v.aDly);
            mem_data_ok   = (k == 2 + v.aDly + v.dDly);
            mem_rdata     = mem_data_ok ? v.rdata : $urandom;
            longest_stall = (k < lat);
            @(negedge clk);
            chk($sformatf("vec%0d_mem_req_c%0d", idx, k), 32'(mem_req), 32'(k >= 1 && k <= 1 + v.aDly));
            chk($sformatf("vec%0d_stall_c%0d", idx, k), 32'(v.isData ? d_stall : i_stall), 32'(k < lat));
            if (k >= 1 && k <= 2 + v.aDly + v.dDly) begin
                chk($sformatf("vec%0d_mem_addr", idx), mem_addr, v.addr);
                chk($sformatf("vec%0d_mem_wr", idx), 32'(mem_wr), 32'(v.expWr));
                chk($sformatf("vec%0d_mem_wen", idx), 32'(mem_wen), 32'(v.expWen));
                if (v.expWr) chk($sformatf("vec%0d_mem_wdata", idx), mem_wdata, v.wdata);
            end
            tick();
        end
        idleInputs();
        @(negedge clk);
        chk($sformatf("vec%0d_inst_rdata", idx), inst_rdata, v.expIRdata);
        chk($sformatf("vec%0d_data_rdata", idx), data_rdata, v.expDRdata);
        tick();
    endtask

    // Random CPU + slave traffic against a transaction-level model:
    // each request is pending until served, the shared port serves the
    // pending data request before the pending fetch, and served requests
    // retire on an edge where the pipeline advances.
    task automatic runRandom(input int nCycles);
        int phase = 0;
        int waitCnt = 0;
        bit ownerData = 0;
        bit iAct = 0, iSrv = 0, dAct = 0, dSrv = 0;
        logic [31:0] iAddr = 0, dAddr = 0, dWdata = 0;
        logic [3:0]  dWen = 0;
        logic [31:0] eAddr = 0, eWdata = 0, eIR = 0, eDR = 0;
        logic        eWr = 0;
        logic [3:0]  eWen = 0;
        bit apA = 0, apD = 0, apLs = 0;
        logic [31:0] apR = 0;
        for (int c = 0; c < nCycles; c++) begin
            tick();
            case (phase)
                2: if (apD) begin
                    if (ownerData) begin
                        dSrv = 1;
                        if (dWen == 0) eDR = apR;
                    end else begin
                        iSrv = 1;
                        eIR = apR;
                    end
                    phase = 0;
                end
                1: if (apA) begin
                    phase = 2;
                    waitCnt = $urandom_range(0, 3);
                end
                default: begin
                    if (dAct && !dSrv) begin
                        ownerData = 1; eAddr = dAddr; eWr = (dWen != 0); eWen = dWen; eWdata = dWdata;
                        phase = 1; waitCnt = $urandom_range(0, 3);
                    end else if (iAct && !iSrv) begin
                        ownerData = 0; eAddr = iAddr; eWr = 0; eWen = 0; eWdata = 0;
                        phase = 1; waitCnt = $urandom_range(0, 3);
                    end
                end
            endcase
            if (!apLs) begin
                if (iAct && iSrv) iAct = 0;
                if (dAct && dSrv) dAct = 0;
            end
            if (!iAct && $urandom_range(0, 2) == 0) begin
                iAct = 1; iSrv = 0; iAddr = $urandom;
            end
            if (!dAct && $urandom_range(0, 2) == 0) begin
                dAct = 1; dSrv = 0; dAddr = $urandom; dWdata = $urandom;
                dWen = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            inst_req   = iAct;
            inst_addr  = iAct ? iAddr : $urandom;
            data_req   = dAct;
            data_addr  = dAct ? dAddr : $urandom;
            data_wen   = dAct ? dWen : 4'($urandom);
            data_wdata = dAct ? dWdata : $urandom;
            mem_addr_ok = 0;
            mem_data_ok = 0;
            if (phase == 1) begin
                if (waitCnt == 0) mem_addr_ok = 1; else waitCnt--;
                mem_data_ok = ($urandom_range(0, 5) == 0);
            end else if (phase == 2) begin
                if (waitCnt == 0) mem_data_ok = 1; else waitCnt--;
                mem_addr_ok = ($urandom_range(0, 5) == 0);
            end else begin
                mem_addr_ok = ($urandom_range(0, 5) == 0);
                mem_data_ok = ($urandom_range(0, 5) == 0);
            end
            mem_rdata = $urandom;
            longest_stall = ($urandom_range(0, 3) == 0) | (iAct & ~iSrv) | (dAct & ~dSrv);
            apA = mem_addr_ok; apD = mem_data_ok; apLs = longest_stall; apR = mem_rdata;
            @(negedge clk);
            chk("rnd_i_stall", 32'(i_stall), 32'(iAct & ~iSrv));
            chk("rnd_d_stall", 32'(d_stall), 32'(dAct & ~dSrv));
            chk("rnd_inst_rdata", inst_rdata, eIR);
            chk("rnd_data_rdata", data_rdata, eDR);
            chk("rnd_mem_req", 32'(mem_req), 32'(phase == 1));
            if (phase != 0) begin
                chk("rnd_mem_addr", mem_addr, eAddr);
                chk("rnd_mem_wr", 32'(mem_wr), 32'(eWr));
                chk("rnd_mem_wen", 32'(mem_wen), 32'(eWen));
                if (eWr) chk("rnd_mem_wdata", mem_wdata, eWdata);
            end
        end
        idleInputs();
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'hBFC00000, 4'h0, 32'h0,        32'h24010001, 0, 0, 1'b0, 4'h0, 32'h24010001, 32'h0};
        vecs[1] = '{1'b1, 32'h80000010, 4'h0, 32'h0,        32'hCAFEF00D, 1, 2, 1'b0, 4'h0, 32'h24010001, 32'hCAFEF00D};
        vecs[2] = '{1'b1, 32'h80000004, 4'h3, 32'h0000BEEF, 32'hDEADDEAD, 0, 0, 1'b1, 4'h3, 32'h24010001, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 32'hBFC00004, 4'h0, 32'h0,        32'h3C1DA000, 4, 5, 1'b0, 4'h0, 32'h3C1DA000, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 32'h80000020, 4'hF, 32'h12345678, 32'h77777777, 2, 1, 1'b1, 4'hF, 32'h3C1DA000, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 32'h80000024, 4'h0, 32'h0,        32'h0BADBEEF, 0, 3, 1'b0, 4'h0, 32'h3C1DA000, 32'h0BADBEEF};

        // Reset values
        idleInputs();
        rst = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_wen", 32'(mem_wen), 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_inst_rdata", inst_rdata, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        rst = 0;
        tick();

        for (int i = 0; i < 6; i++) runVec(vecs[i], i);

        // Simultaneous fetch and load: data first, inst second
        inst_req = 1; inst_addr = 32'hBFC00008;
        data_req = 1; data_wen = 0; data_addr = 32'h80000010; data_wdata = 0;
        longest_stall = 1;
        @(negedge clk);
        chk("sim_c0_d_stall", 32'(d_stall), 32'h1);
        chk("sim_c0_i_stall", 32'(i_stall), 32'h1);
        tick(); mem_addr_ok = 1;
        @(negedge clk);
        chk("sim_c1_mem_req", 32'(mem_req), 32'h1);
        chk("sim_c1_mem_addr", mem_addr, 32'h80000010);
        tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h11112222;
        @(negedge clk);
        chk("sim_c2_mem_req", 32'(mem_req), 32'h0);
        tick(); mem_data_ok = 0;
        @(negedge clk);
        chk("sim_c3_d_stall", 32'(d_stall), 32'h0);
        chk("sim_c3_i_stall", 32'(i_stall), 32'h1);
        chk("sim_c3_data_rdata", data_rdata, 32'h11112222);
        chk("sim_c3_mem_req", 32'(mem_req), 32'h0);
        tick(); mem_addr_ok = 1;
        @(negedge clk);
        chk("sim_c4_mem_req", 32'(mem_req), 32'h1);
        chk("sim_c4_mem_addr", mem_addr, 32'hBFC00008);
        chk("sim_c4_mem_wr", 32'(mem_wr), 32'h0);
        tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h33334444;
        @(negedge clk);
        chk("sim_c5_d_stall_held", 32'(d_stall), 32'h0);
        chk("sim_c5_i_stall", 32'(i_stall), 32'h1);
        tick(); mem_data_ok = 0;
        @(negedge clk);
        chk("sim_c6_i_stall", 32'(i_stall), 32'h0);
        chk("sim_c6_inst_rdata", inst_rdata, 32'h33334444);
        tick(); longest_stall = 0;
        @(negedge clk);
        chk("sim_c7_i_stall_held", 32'(i_stall), 32'h0);
        chk("sim_c7_d_stall_held", 32'(d_stall), 32'h0);
        tick();
        @(negedge clk);
        chk("sim_c8_i_clear", 32'(i_stall), 32'h1);
        chk("sim_c8_d_clear", 32'(d_stall), 32'h1);
        idleInputs();
        tick();

        // Fetch flushed after issue: runs to completion, flag set then cleared
        inst_req = 1; inst_addr = 32'hBFC00100; longest_stall = 1;
        @(negedge clk);
        chk("fl_c0_mem_req", 32'(mem_req), 32'h0);
        tick(); inst_req = 0; longest_stall = 0;
        @(negedge clk);
        chk("fl_c1_mem_req", 32'(mem_req), 32'h1);
        chk("fl_c1_mem_addr", mem_addr, 32'hBFC00100);
        tick(); mem_addr_ok = 1;
        @(negedge clk);
        chk("fl_c2_mem_req", 32'(mem_req), 32'h1);
        tick(); mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h5555AAAA;
        @(negedge clk);
        tick(); mem_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00104;
        @(negedge clk);
        chk("fl_c4_inst_rdata", inst_rdata, 32'h5555AAAA);
        chk("fl_c4_i_stall_done", 32'(i_stall), 32'h0);
        tick();
        @(negedge clk);
        chk("fl_c5_i_stall_clear", 32'(i_stall), 32'h1);
        chk("fl_c5_mem_req", 32'(mem_req), 32'h0);
        inst_req = 0;
        tick();

        // Reset while in DATA, then a stray completion
        data_req = 1; data_wen = 0; data_addr = 32'h80000030; longest_stall = 1;
        @(negedge clk);
        tick(); mem_addr_ok = 1;
        @(negedge clk);
        chk("rd_c1_mem_req", 32'(mem_req), 32'h1);
        tick(); mem_addr_ok = 0;
        @(negedge clk);
        chk("rd_c2_mem_req", 32'(mem_req), 32'h0);
        rst = 1; data_req = 0; longest_stall = 0;
        #2 rst = 0;
        tick(); mem_data_ok = 1; mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("rd_c3_mem_req", 32'(mem_req), 32'h0);
        tick(); mem_data_ok = 0;
        @(negedge clk);
        chk("rd_c4_data_rdata", data_rdata, 32'h0);
        chk("rd_c4_inst_rdata", inst_rdata, 32'h0);
        chk("rd_c4_mem_addr", mem_addr, 32'h0);
        chk("rd_c4_mem_wr", 32'(mem_wr), 32'h0);
        chk("rd_c4_mem_wen", 32'(mem_wen), 32'h0);
        chk("rd_c4_mem_wdata", mem_wdata, 32'h0);
        chk("rd_c4_mem_req", 32'(mem_req), 32'h0);
        data_req = 1; data_addr = 32'h80000040; longest_stall = 1;
        #1;
        chk("rd_c4_no_done", 32'(d_stall), 32'h1);
        tick();
        @(negedge clk);
        chk("rd_c5_mem_req", 32'(mem_req), 32'h1);
        chk("rd_c5_mem_addr", mem_addr, 32'h80000040);
        idleInputs();
        rst = 1;
        #2 rst = 0;
        tick();

        runRandom(3000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (address/data 32, byte enable 4).
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 inst_req / inst_addr  in  1/32  CPU fetch request, held by CPU while stalled.
REQ-005 inst_rdata / i_stall  out  32/1  fetched word; fetch-not-complete.
REQ-006 data_req / data_wen / data_addr / data_wdata  in  1/4/32/32  CPU load/store request; data_wen!=0 means store.
REQ-007 data_rdata / d_stall  out  32/1  loaded word; access-not-complete.
REQ-008 longest_stall  in  1  pipeline frozen this cycle (OR of all CPU stalls).
REQ-009 mem_req / mem_wr / mem_wen / mem_addr / mem_wdata  out  1/1/4/32/32  single shared downstream port.
REQ-010 mem_addr_ok / mem_data_ok / mem_rdata  in  1/1/32  downstream address accept, completion, read data.

Function
REQ-011 FSM states IDLE, ADDR, DATA; exactly one downstream transaction outstanding at any time.
REQ-012 Flags inst_done, data_done (registered); i_stall = inst_req & ~inst_done, d_stall = data_req & ~data_done, both combinational.
REQ-013 IDLE: if d_stall, latch data request into mem_* registers and go ADDR; else if i_stall, latch inst request (mem_wr=0, mem_wen=0) and go ADDR; else stay.
REQ-014 Priority fixed: data over inst when both pending in IDLE; no preemption of a started transaction.
REQ-015 Store latching: mem_wr=1, mem_wen=data_wen, mem_wdata=data_wdata; load: mem_wr=0, mem_wen=0.
REQ-016 mem_req=1 only in ADDR; mem_addr/mem_wr/mem_wen/mem_wdata stable from ADDR entry until return to IDLE.
REQ-017 ADDR: on mem_addr_ok go DATA (mem_req low the next cycle); else hold.
REQ-018 DATA: on mem_data_ok go IDLE, set owner's done flag; if owner is a read, capture mem_rdata into inst_rdata or data_rdata.
REQ-019 mem_data_ok in IDLE/ADDR and mem_addr_ok outside ADDR are ignored.
REQ-020 Minimum latency: request seen in IDLE at cycle N -> mem_req at N+1; addr_ok at N+1 and data_ok at N+2 -> done flag high, stall low at N+3.
REQ-021 Done flags clear at a clock edge where longest_stall=0; set takes precedence over clear in the same cycle.
REQ-022 inst_rdata/data_rdata hold value until next read completion of the same owner; stores do not alter data_rdata.
REQ-023 Request dropped mid-transaction (flush): transaction runs to completion, result and done flag updated normally, flag clears per REQ-021.
REQ-024 Back-to-back: after completion, IDLE may start the other owner's pending request in the cycle following DATA exit.

Reset
REQ-025 On rst: state IDLE, done flags 0, mem_req 0, mem_wr 0, mem_wen 0, mem_addr 0, mem_wdata 0, inst_rdata 0, data_rdata 0.
REQ-026 Reset mid-ADDR/DATA abandons the transaction; subsequent stray mem_data_ok ignored per REQ-019.

Verification
REQ-027 Inst fetch alone: inst_req=1, addr 0xBFC00000, addr_ok immediate, data_ok next cycle with 0x24010001 -> i_stall low 3 cycles after request, inst_rdata=0x24010001.
REQ-028 Simultaneous: inst_req and data_req (load 0x80000010) same cycle -> data issued first, inst second; d_stall falls before i_stall; inst_done held while longest_stall=1, both flags clear once longest_stall=0.
REQ-029 Store: data_wen=0x3, addr 0x80000004, wdata 0x0000BEEF -> mem_wr=1, mem_wen=0x3 on mem port; data_rdata unchanged.
REQ-030 Slow slave: addr_ok delayed 4 cycles, data_ok delayed 5 more -> mem_req high exactly until addr_ok, mem_* stable throughout, stall high until done.
REQ-031 rst pulsed while in DATA, then stray mem_data_ok -> state IDLE, all outputs reset values, no rdata capture, no done flag set.
